scanner_sequencer: RTL

Sequences the single active LED of the scanner bar. It sweeps the LED back and forth across NUM_LEDS positions and holds it for an extra step at each end. Step rate is chosen from 4 speed levels, cycled by a user button. The active LED is gated by pwm_enable from the brightness controller to produce the final LED drive.

---
 rtl/scanner_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/scanner_sequencer.sv
// scanner_sequencer
//   Moves the single active LED of the scanner bar back and forth across
//   NUM_LEDS positions, holding it for one extra step at each end. Four step
//   rates are selectable, and a button cycles through them. The lit LED is
//   gated by the brightness PWM.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   change_speed asynchronous button; each rising edge advances speed_sel
//   pause        asynchronous level; high freezes the sweep
//   pwm_enable   brightness gate, synchronous to clk
//   leds         registered one-hot LED drive, gated by pwm_enable
//   position     current active LED index
//   direction    1 = heading up, 0 = heading down
//   speed_sel    current speed level (0 = slowest)
//   step_tick    one-cycle pulse on each step boundary
module scanner_sequencer #(
  parameter int CLK_FREQ        = 6000,
  parameter int NUM_LEDS        = 8,
  parameter int STEP_BASE       = CLK_FREQ / 4,
  parameter int STEP_CNTR_WIDTH = 16,
  localparam int POS_W          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                change_speed,
  input  logic                pause,
  input  logic                pwm_enable,
  output logic [NUM_LEDS-1:0] leds,
  output logic [POS_W-1:0]    position,
  output logic                direction,
  output logic [1:0]          speed_sel,
  output logic                step_tick
);

  localparam logic [STEP_CNTR_WIDTH-1:0] BASE     = STEP_CNTR_WIDTH'(STEP_BASE);
  localparam logic [STEP_CNTR_WIDTH-1:0] CNT_ONE  = STEP_CNTR_WIDTH'(1);
  localparam logic [POS_W-1:0]           POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]           POS_ONE  = POS_W'(1);

  typedef enum logic [1:0] {
    SCAN_UP      = 2'd0,
    DWELL_TOP    = 2'd1,
    SCAN_DOWN    = 2'd2,
    DWELL_BOTTOM = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 cs_sr_q, cs_sr_d;
  logic [1:0]                 pause_sync_q, pause_sync_d;
  logic [1:0]                 speed_q, speed_d;
  logic [STEP_CNTR_WIDTH-1:0] cntr_q, cntr_d;
  logic                       tick_q, tick_d;
  logic [POS_W-1:0]           pos_q, pos_d;
  logic                       dir_q, dir_d;
  logic [NUM_LEDS-1:0]        leds_q, leds_d;

  logic                       pause_s;
  logic                       speed_rise;
  logic                       step_evt;
  logic [STEP_CNTR_WIDTH-1:0] period;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SCAN_UP;
      cs_sr_q      <= '0;
      pause_sync_q <= '0;
      speed_q      <= '0;
      cntr_q       <= '0;
      tick_q       <= 1'b0;
      pos_q        <= '0;
      dir_q        <= 1'b1;
      leds_q       <= '0;
    end else begin
      state_q      <= state_d;
      cs_sr_q      <= cs_sr_d;
      pause_sync_q <= pause_sync_d;
      speed_q      <= speed_d;
      cntr_q       <= cntr_d;
      tick_q       <= tick_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      leds_q       <= leds_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;

    // Button path: bits [1:0] synchronize, bits [3:2] hold the two oldest
    // samples for edge detection. Newest sample enters at bit 0, so a rise
    // shows up three clocks after the pin is first sampled high.
    cs_sr_d    = {cs_sr_q[2:0], change_speed};
    speed_rise = cs_sr_q[2] & ~cs_sr_q[3];
    speed_d    = speed_rise ? speed_q + 2'd1 : speed_q;

    pause_sync_d = {pause_sync_q[0], pause};
    pause_s      = pause_sync_q[1];

    // >= rather than == so a speed-up that leaves the count past the new
    // terminal value still ends the step on the next clock.
    period   = BASE >> speed_q;
    step_evt = !pause_s && (cntr_q >= period - CNT_ONE);

    if (pause_s)       cntr_d = cntr_q;
    else if (step_evt) cntr_d = '0;
    else               cntr_d = cntr_q + CNT_ONE;
    tick_d = step_evt;

    if (step_evt) begin
      case (state_q)
        SCAN_UP: begin
          pos_d = pos_q + POS_ONE;
          if (pos_d == POS_LAST) state_d = DWELL_TOP;
        end
        DWELL_TOP:    state_d = SCAN_DOWN;
        SCAN_DOWN: begin
          pos_d = pos_q - POS_ONE;
          if (pos_d == '0) state_d = DWELL_BOTTOM;
        end
        DWELL_BOTTOM: state_d = SCAN_UP;
        default: begin
          state_d = SCAN_UP;
          pos_d   = '0;
        end
      endcase
    end

    // Direction follows the state, so during a dwell it already shows the
    // heading the bar will take once the dwell ends.
    dir_d = (state_d == SCAN_UP) || (state_d == DWELL_BOTTOM);

    leds_d = '0;
    if (pwm_enable) leds_d[pos_q] = 1'b1;
  end

  assign leds      = leds_q;
  assign position  = pos_q;
  assign direction = dir_q;
  assign speed_sel = speed_q;
  assign step_tick = tick_q;

endmodule
